hd_candidate_scan: RTL and testbench
====================================

# hd_candidate_scan

Parametrised Hamming-distance candidate scanner for the ICBLBC code search. Given a start codeword, it sweeps every word of an n-bit space in a fully pipelined manner, one word per clock. Words meeting the code distance threshold go into an A-candidate buffer, and words meeting the isolation threshold go into a B-candidate buffer, both in ascending order. It feeds the iso-search stage, which reads both buffers through a registered read port once `done` pulses.

## Interface
- `WIDTH`, default 8: codeword width in bits; maximum scan space is 2^WIDTH.
- `CW`, default $clog2(WIDTH+1): width of distance and threshold fields.
- `AW`, default WIDTH+1: width of the count fields.
- `clock` input 1: sole clock; all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: level sampled in IDLE; high for one cycle launches a scan.
- `abort` input 1: cancels a scan in progress.
- `start_word` input WIDTH: reference codeword, captured at start.
- `n_bits` input CW: scan space exponent, captured at start; values above WIDTH clamp to WIDTH.
- `min_hd` input CW: A-candidate threshold (distance >= min_hd), captured at start.
- `min_iso` input CW: B-candidate threshold (distance >= min_iso), captured at start.
- `busy` output 1: scan in progress.
- `done` output 1: one-cycle pulse at scan completion.
- `cand_count` output AW: number of A-candidates written.
- `b_cand_count` output AW: number of B-candidates written.
- `rd_sel` input 1: buffer select; 0 = A, 1 = B.
- `rd_addr` input WIDTH: read index.
- `rd_data` output WIDTH: buffer word, registered.

## Operation
- States:
  - IDLE: `start`=1 and `abort`=0 → latch inputs, clear both counts and the scan counter, go to SCAN.
  - SCAN: issue counter k = 0 … 2^n−1, one value per cycle; after issuing 2^n−1 → DRAIN.
  - DRAIN: wait until the pipeline is empty → DONE.
  - DONE: pulse `done` for one cycle → IDLE.
- Pipeline, three stages:
  - S0: issue k.
  - S1: register popcount(k ^ start_word_latched), where the latched start word is masked to n bits.
  - S2: compare and write. If dist >= min_hd, write k to A[cand_count] and increment cand_count. If dist >= min_iso, write k to B[b_cand_count] and increment b_cand_count. Both buffers may be written in the same cycle.
- Distances and thresholds are unsigned CW-bit values. A threshold of 0 accepts every word. A threshold above n accepts none.
- Counts saturate at 2^WIDTH and cannot overflow AW bits.
- `start` during SCAN, DRAIN or DONE is ignored.
- `abort`:
  - In SCAN or DRAIN, `abort` sends the block to IDLE on the next edge. In-flight pipeline writes are discarded and no `done` is produced. Counts hold their partial values.
  - `abort` in IDLE has priority over `start`.
- Buffers are not cleared by reset or by start. Only entries below the respective count are defined.
- Read port: `rd_data` = buf[rd_sel][rd_addr], registered with one-cycle latency. Contents are guaranteed only after `done` and until the next start.
- Reset values: state IDLE, `busy`=0, `done`=0, both counts 0, `rd_data`=0, pipeline valids 0. Asserting reset mid-scan returns the block to IDLE immediately, with no `done`.

## Timing
- Edge E0 samples `start`. `busy` rises after E0.
- Word k is issued in the cycle following E0+k. It is written at edge E0+k+2.
- The last write occurs at edge E0+2^n+1.
- `done` is high in the cycle following edge E0+2^n+2. `busy` falls on that same edge.
- Total scan latency from start to done is 2^n+2 edges. Throughput is one word per cycle.
- Counts are final and stable when `done` is high.
- The earliest next start is sampled one cycle after the `done` cycle.

## Test plan
- WIDTH=8, start_word=0x00, n=8, min_hd=8, min_iso=7 → expected results:
  - cand_count=1, A[0]=0xFF.
  - b_cand_count=9, B = 0x7F, 0xBF, 0xDF, 0xEF, 0xF7, 0xFB, 0xFD, 0xFE, 0xFF.
  - `done` 258 edges after start.
- start_word=0x05, n=3, min_hd=2, min_iso=3 → expected results:
  - A = 0, 2, 3, 6, so cand_count=4.
  - B = 2, so b_cand_count=1.
  - `done` 10 edges after start.
- Threshold boundaries:
  - min_hd=0, n=4 → cand_count=16, A[i]=i.
  - min_iso=5, n=4 → b_cand_count=0.
  - n_bits=12 with WIDTH=8 → behaves as n=8.
- Abort: assert `abort` 20 cycles into an n=8 scan → block is in IDLE next cycle, `done` never pulses, counts are frozen. Then assert `start` and `abort` together in IDLE → no scan starts.
- Start while busy and reset: pulse `start` during SCAN → ignored, with an identical result and `done` timing. Deassert `reset_n` mid-scan → outputs go to reset values asynchronously. A fresh scan after reset release gives correct counts.

Source files
------------

// File: rtl/hd_candidate_scan.sv
// hd_candidate_scan
// Sweeps every word of an n-bit space, one word per clock, and measures the
// Hamming distance of each word to a reference codeword. Words that reach the
// code distance threshold are appended to the A buffer, and words that reach
// the isolation threshold are appended to the B buffer. Both buffers fill in
// ascending word order. A downstream stage reads them through one registered
// read port after `done` pulses.
module hd_candidate_scan #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1),
  parameter int AW    = WIDTH + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] start_word,
  input  logic [CW-1:0]    n_bits,
  input  logic [CW-1:0]    min_hd,
  input  logic [CW-1:0]    min_iso,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    cand_count,
  output logic [AW-1:0]    b_cand_count,
  input  logic             rd_sel,
  input  logic [WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << WIDTH;
  // A count can never legally exceed the buffer depth.
  localparam logic [AW-1:0] COUNT_MAX = AW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                  state_reg;
  logic                    busy_reg;
  logic                    done_reg;

  // Parameters latched at start.
  logic [WIDTH-1:0]        word_reg;   // reference word, masked to n bits
  logic [WIDTH-1:0]        mask_reg;   // 2^n - 1, also the last issued value
  logic [1:0][CW-1:0]      thr_reg;    // [0] = min_hd, [1] = min_iso

  // S0: issue counter.
  logic [WIDTH-1:0]        k_reg;

  // S1: word and its distance to the reference.
  logic                    s1_valid_reg;
  logic [WIDTH-1:0]        s1_k_reg;
  logic [CW-1:0]           s1_dist_reg;

  logic                    rd_sel_reg;

  logic                    launch;
  logic                    kill;
  logic                    issue;
  logic [CW-1:0]           n_clamped;
  logic [WIDTH-1:0]        start_mask;
  logic [WIDTH-1:0]        diff;
  logic [CW-1:0]           dist_next;

  // A scan launches from IDLE only; abort outranks start.
  assign launch = (state_reg == ST_IDLE) && start && !abort;
  // Abort while the pipeline is live throws away whatever is in flight.
  assign kill   = abort && ((state_reg == ST_SCAN) || (state_reg == ST_DRAIN));
  // A new word enters the pipeline every SCAN cycle unless aborting.
  assign issue  = (state_reg == ST_SCAN) && !abort;

  // Clamp the space exponent and build the n-bit mask for the start word.
  always_comb begin
    n_clamped  = (int'(n_bits) > WIDTH) ? CW'(WIDTH) : n_bits;
    start_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      start_mask[i] = (i < int'(n_clamped));
    end
  end

  // Popcount of the issued word against the latched reference.
  always_comb begin
    diff      = k_reg ^ word_reg;
    dist_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dist_next = dist_next + CW'(diff[i]);
    end
  end

  // Control FSM: sequences IDLE -> SCAN -> DRAIN -> DONE, drives busy/done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      word_reg  <= '0;
      mask_reg  <= '0;
      thr_reg   <= '0;
      k_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (launch) begin
            state_reg  <= ST_SCAN;
            busy_reg   <= 1'b1;
            word_reg   <= start_word & start_mask;
            mask_reg   <= start_mask;
            thr_reg[0] <= min_hd;
            thr_reg[1] <= min_iso;
            k_reg      <= '0;
          end
        end
        ST_SCAN: begin
          if (abort) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else if (k_reg == mask_reg) begin
            state_reg <= ST_DRAIN;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          // The final word is written on the edge that empties S1.
          if (abort) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else if (!s1_valid_reg) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // S1 register: capture the issued word with its distance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s1_k_reg     <= '0;
      s1_dist_reg  <= '0;
    end else begin
      s1_valid_reg <= issue;
      s1_k_reg     <= k_reg;
      s1_dist_reg  <= dist_next;
    end
  end

  // Two candidate banks that share the S2 compare. They differ only in
  // their threshold: bank 0 is A (min_hd), and bank 1 is B (min_iso).
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    count_reg;
    logic [WIDTH-1:0] q_reg;
    logic             wr_en;

    assign wr_en = s1_valid_reg && !kill &&
                   (s1_dist_reg >= thr_reg[gi]) &&
                   (count_reg != COUNT_MAX);

    // Append counter: cleared on launch, saturating at the buffer depth.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        count_reg <= '0;
      end else if (launch) begin
        count_reg <= '0;
      end else if (wr_en) begin
        count_reg <= count_reg + 1'b1;
      end
    end

    // Candidate storage. It is not reset, so it maps onto block RAM.
    always_ff @(posedge clock) begin
      if (wr_en) begin
        mem[count_reg[WIDTH-1:0]] <= s1_k_reg;
      end
    end

    // Registered read of this bank.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        q_reg <= '0;
      end else begin
        q_reg <= mem[rd_addr];
      end
    end
  end

  // Register the bank select so it lines up with the registered bank data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_sel_reg <= 1'b0;
    end else begin
      rd_sel_reg <= rd_sel;
    end
  end

  assign rd_data      = rd_sel_reg ? g_bank[1].q_reg : g_bank[0].q_reg;
  assign cand_count   = g_bank[0].count_reg;
  assign b_cand_count = g_bank[1].count_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_hd_candidate_scan.sv
// Scoreboard bench for hd_candidate_scan: scan and read expectations are
// queued by the stimulus, and a negedge monitor checks them against DUT output.
module tb_hd_candidate_scan;

  localparam int WIDTH = 8;
  localparam int CW    = 4;
  localparam int AW    = 9;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] start_word;
  logic [CW-1:0]    n_bits;
  logic [CW-1:0]    min_hd;
  logic [CW-1:0]    min_iso;
  logic             busy;
  logic             done;
  logic [AW-1:0]    cand_count;
  logic [AW-1:0]    b_cand_count;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;

  hd_candidate_scan #(.WIDTH(WIDTH), .CW(CW), .AW(AW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .start_word   (start_word),
    .n_bits       (n_bits),
    .min_hd       (min_hd),
    .min_iso      (min_iso),
    .busy         (busy),
    .done         (done),
    .cand_count   (cand_count),
    .b_cand_count (b_cand_count),
    .rd_sel       (rd_sel),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic rd_req   = 1'b0;
  logic rd_req_d = 1'b0;
  always @(posedge clock) rd_req_d <= rd_req;

  typedef struct {
    int    a;
    int    b;
    int    done_cyc;
    string name;
  } scan_exp_t;

  typedef struct {
    logic [WIDTH-1:0] exp;
    bit               sel;
    int               addr;
  } rd_exp_t;

  scan_exp_t scan_q[$];
  rd_exp_t   rd_q[$];

  int total = 0;
  int bad   = 0;

  logic [7:0] b_full [9] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFF};
  logic [7:0] a_t2   [4] = '{8'h00, 8'h02, 8'h03, 8'h06};

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scores every done pulse and every read response.
  always @(negedge clock) begin
    scan_exp_t se;
    rd_exp_t   re;
    if (done) begin
      if (scan_q.size() == 0) begin
        check("unexpected_done", int'(done), 0);
      end else begin
        se = scan_q.pop_front();
        check({se.name, "_cand_count"}, int'(cand_count), se.a);
        check({se.name, "_b_cand_count"}, int'(b_cand_count), se.b);
        check({se.name, "_done_cycle"}, cyc, se.done_cyc);
        check({se.name, "_busy_at_done"}, int'(busy), 0);
      end
    end
    if (rd_req_d) begin
      if (rd_q.size() == 0) begin
        check("rd_queue_empty", 1, int'(rd_q.size()));
      end else begin
        re = rd_q.pop_front();
        check($sformatf("rd_%s[%0d]", re.sel ? "B" : "A", re.addr), int'(rd_data), int'(re.exp));
      end
    end
  end

  task automatic launch(input logic [7:0] sw, input int nb, input int mh, input int mi,
                        input bit push, input int ea, input int eb, input int n_eff,
                        input string name);
    scan_exp_t se;
    @(negedge clock);
    start_word = sw;
    n_bits     = nb[CW-1:0];
    min_hd     = mh[CW-1:0];
    min_iso    = mi[CW-1:0];
    start      = 1'b1;
    if (push) begin
      se.a        = ea;
      se.b        = eb;
      se.done_cyc = cyc + (1 << n_eff) + 3;
      se.name     = name;
      scan_q.push_back(se);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (scan_q.size() != 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (scan_q.size() != 0) begin
      check("done_timeout", int'(scan_q.size()), 0);
      scan_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic rd(input bit sel, input int addr, input logic [7:0] exp);
    rd_exp_t re;
    rd_sel  = sel;
    rd_addr = addr[WIDTH-1:0];
    rd_req  = 1'b1;
    re.exp  = exp;
    re.sel  = sel;
    re.addr = addr;
    rd_q.push_back(re);
    @(negedge clock);
  endtask

  task automatic rd_end();
    rd_req = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    start_word = '0;
    n_bits     = '0;
    min_hd     = '0;
    min_iso    = '0;
    rd_sel     = 1'b0;
    rd_addr    = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_cand_count", int'(cand_count), 0);
    check("reset_b_cand_count", int'(b_cand_count), 0);
    check("reset_rd_data", int'(rd_data), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Full 8-bit space from 0x00: only 0xFF reaches 8, and nine words reach 7.
    launch(8'h00, 8, 8, 7, 1'b1, 1, 9, 8, "full8");
    check("full8_busy_after_start", int'(busy), 1);
    wait_done();
    rd(1'b0, 0, 8'hFF);
    for (int i = 0; i < 9; i++) rd(1'b1, i, b_full[i]);
    rd_end();

    // Small space from 0x05.
    launch(8'h05, 3, 2, 3, 1'b1, 4, 1, 3, "n3");
    wait_done();
    for (int i = 0; i < 4; i++) rd(1'b0, i, a_t2[i]);
    rd(1'b1, 0, 8'h02);
    rd_end();

    // A threshold of 0 accepts all words, and a threshold above n accepts none.
    launch(8'h00, 4, 0, 5, 1'b1, 16, 0, 4, "thr");
    wait_done();
    for (int i = 0; i < 16; i++) rd(1'b0, i, i[7:0]);
    rd_end();

    // n_bits beyond WIDTH clamps to WIDTH.
    launch(8'h00, 12, 8, 7, 1'b1, 1, 9, 8, "clamp");
    wait_done();
    rd(1'b0, 0, 8'hFF);
    rd(1'b1, 0, 8'h7F);
    rd(1'b1, 8, 8'hFF);
    rd_end();

    // Abort 20 cycles in. Words 0..17 are written, and the write of word 18 is dropped.
    launch(8'h00, 8, 0, 0, 1'b0, 0, 0, 8, "abort");
    repeat (19) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_cand_count", int'(cand_count), 18);
    check("abort_b_cand_count", int'(b_cand_count), 18);
    repeat (300) @(negedge clock);
    check("abort_cand_frozen", int'(cand_count), 18);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", int'(busy), 0);
    check("start_abort_cand_kept", int'(cand_count), 18);
    @(negedge clock);
    check("start_abort_busy_later", int'(busy), 0);

    // A second start pulse while busy, with different inputs, is ignored.
    launch(8'h05, 3, 2, 3, 1'b1, 4, 1, 3, "restart");
    repeat (2) @(negedge clock);
    start_word = 8'hFF;
    n_bits     = 4'd8;
    min_hd     = 4'd0;
    min_iso    = 4'd0;
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done();
    for (int i = 0; i < 4; i++) rd(1'b0, i, a_t2[i]);
    rd(1'b1, 0, 8'h02);
    rd_end();

    // Asynchronous reset in the middle of a scan.
    rd_sel  = 1'b0;
    rd_addr = 8'd5;
    launch(8'h00, 8, 0, 0, 1'b0, 0, 0, 8, "rst");
    repeat (30) @(negedge clock);
    check("pre_reset_rd_data", int'(rd_data), 5);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_cand_count", int'(cand_count), 0);
    check("midreset_b_cand_count", int'(b_cand_count), 0);
    check("midreset_rd_data", int'(rd_data), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    launch(8'h05, 3, 2, 3, 1'b1, 4, 1, 3, "post_reset");
    wait_done();
    for (int i = 0; i < 4; i++) rd(1'b0, i, a_t2[i]);
    rd(1'b1, 0, 8'h02);
    rd_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
